// File: rtl/jtag_ir_dr_regs_pkg.sv
// rtl/jtag_ir_dr_regs_pkg.sv - JTAG opcodes, IR capture pattern and DR select type
package jtag_pkg;

    localparam logic [3:0] OP_BYPASS  = 4'b1111;
    localparam logic [3:0] OP_IDCODE  = 4'b0001;
    localparam logic [3:0] OP_USER    = 4'b1000;
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

endpackage

// File: rtl/jtag_ir_dr_regs_if.sv
// rtl/jtag_ir_dr_regs_if.sv - TAP strobe / scan-path bundle between TAP and IR/DR block
interface jtag_ir_dr_regs_if #(
    parameter int IR_W   = 4,
    parameter int USER_W = 16
);
    logic              tdi;
    logic              cdr1;
    logic              sdr1;
    logic              udr1;
    logic              cir1;
    logic              sir1;
    logic              uir1;
    logic [USER_W-1:0] user_din;
    logic              tdo;
    logic              tdo_oe;
    logic [IR_W-1:0]   instr;
    logic [USER_W-1:0] user_dout;
    logic              user_upd;

    // TAP side: drives strobes and scan input, observes scan output
    modport master (
        output tdi, cdr1, sdr1, udr1, cir1, sir1, uir1, user_din,
        input  tdo, tdo_oe, instr, user_dout, user_upd
    );

    // Register side: consumes strobes, owns the scan path
    modport slave (
        input  tdi, cdr1, sdr1, udr1, cir1, sir1, uir1, user_din,
        output tdo, tdo_oe, instr, user_dout, user_upd
    );
endinterface

// File: rtl/jtag_shift_reg.sv
// rtl/jtag_shift_reg.sv - capture/shift register, LSB out first, capture wins over shift
module jtag_shift_reg #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         tck,
    input  logic         trst,
    input  logic         cap,
    input  logic         shift,
    input  logic [W-1:0] cap_val,
    input  logic         tdi,
    output logic [W-1:0] q,
    output logic         so
);

    // Parallel capture, else serial shift toward bit 0 with tdi entering at the MSB
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            q <= RST_VAL;
        end else if (cap) begin
            q <= cap_val;
        end else if (shift) begin
            q <= {tdi, q[W-1:1]};
        end
    end

    assign so = q[0];

endmodule

// File: rtl/jtag_ir_dr_regs.sv
// rtl/jtag_ir_dr_regs.sv - JTAG IR and BYPASS/IDCODE/USER DRs with scan path; USER DR gated by JTAG_USER_DR_EN
module jtag_ir_dr_regs
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5677,
    parameter int          USER_W     = 16
) (
    input  logic            tck,
    input  logic            trst,
    jtag_ir_dr_regs_if.slave bus
);

    localparam logic [IR_W-1:0] OP_BYPASS_W = '1;
    localparam logic [IR_W-1:0] OP_IDCODE_W = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_CAP_W    = IR_W'(IR_CAPTURE);

    logic [IR_W-1:0] ir_sr;
    logic            ir_so;
    logic [IR_W-1:0] instr_q;
    logic            bypass_sr;
    logic [31:0]     idcode_sr;
    logic            idcode_so;
    logic            user_so;
    dr_sel_t         dr_sel;

    // Any IR strobe blocks the whole DR group on that edge
    logic dr_ok;
    logic dr_cap;
    logic dr_shift;
    logic ir_upd;

    assign dr_ok    = ~(bus.cir1 | bus.sir1 | bus.uir1);
    assign dr_cap   = dr_ok & bus.cdr1;
    assign dr_shift = dr_ok & ~bus.cdr1 & bus.sdr1;
    assign ir_upd   = ~bus.cir1 & ~bus.sir1 & bus.uir1;

    jtag_shift_reg #(.W(IR_W), .RST_VAL('0)) u_ir (
        .tck     (tck),
        .trst    (trst),
        .cap     (bus.cir1),
        .shift   (bus.sir1),
        .cap_val (IR_CAP_W),
        .tdi     (bus.tdi),
        .q       (ir_sr),
        .so      (ir_so)
    );

    // Update latch for the instruction; resets to IDCODE so a fresh TAP reads the chip ID
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            instr_q <= OP_IDCODE_W;
        end else if (ir_upd) begin
            instr_q <= ir_sr;
        end
    end

    // Instruction decode; every unknown opcode falls back to bypass
    always_comb begin
        dr_sel = DR_BYPASS;
        if (instr_q == OP_IDCODE_W) begin
            dr_sel = DR_IDCODE;
        end
`ifdef JTAG_USER_DR_EN
        else if (instr_q == IR_W'(OP_USER)) begin
            dr_sel = DR_USER;
        end
`endif
        else if (instr_q == OP_BYPASS_W) begin
            dr_sel = DR_BYPASS;
        end
    end

    // Single-flop bypass register: captures 0, shifts tdi straight through
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass_sr <= 1'b0;
        end else if (dr_sel == DR_BYPASS) begin
            if (dr_cap) begin
                bypass_sr <= 1'b0;
            end else if (dr_shift) begin
                bypass_sr <= bus.tdi;
            end
        end
    end

    jtag_shift_reg #(.W(32), .RST_VAL(IDCODE_VAL)) u_idcode (
        .tck     (tck),
        .trst    (trst),
        .cap     (dr_cap & (dr_sel == DR_IDCODE)),
        .shift   (dr_shift & (dr_sel == DR_IDCODE)),
        .cap_val (IDCODE_VAL),
        .tdi     (bus.tdi),
        .q       (idcode_sr),
        .so      (idcode_so)
    );

`ifdef JTAG_USER_DR_EN
    logic [USER_W-1:0] user_sr;
    logic [USER_W-1:0] user_dout_q;
    logic              user_upd_q;
    logic              dr_upd;

    assign dr_upd = dr_ok & ~bus.cdr1 & ~bus.sdr1 & bus.udr1;

    jtag_shift_reg #(.W(USER_W), .RST_VAL('0)) u_user (
        .tck     (tck),
        .trst    (trst),
        .cap     (dr_cap & (dr_sel == DR_USER)),
        .shift   (dr_shift & (dr_sel == DR_USER)),
        .cap_val (bus.user_din),
        .tdi     (bus.tdi),
        .q       (user_sr),
        .so      (user_so)
    );

    // USER update latch and its one-cycle write pulse
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            user_dout_q <= '0;
            user_upd_q  <= 1'b0;
        end else begin
            user_upd_q <= dr_upd & (dr_sel == DR_USER);
            if (dr_upd && dr_sel == DR_USER) begin
                user_dout_q <= user_sr;
            end
        end
    end

    assign bus.user_dout = user_dout_q;
    assign bus.user_upd  = user_upd_q;
`else
    assign user_so       = 1'b0;
    assign bus.user_dout = '0;
    assign bus.user_upd  = 1'b0;
`endif

    logic sel_so;

    // Serial output of whichever DR the current instruction selects
    always_comb begin
        sel_so = bypass_sr;
        case (dr_sel)
            DR_IDCODE: sel_so = idcode_so;
            DR_USER:   sel_so = user_so;
            default:   sel_so = bypass_sr;
        endcase
    end

    assign bus.tdo    = bus.sir1 ? ir_so : (bus.sdr1 ? sel_so : 1'b0);
    assign bus.tdo_oe = bus.sir1 | bus.sdr1;
    assign bus.instr  = instr_q;

endmodule
